alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives one ALU unit through ISSUE/SETTLE/CAPTURE and latches its result and flags.
// Optional macro ALU_SEQ_FLAG_PRESERVE_EN: flags an opcode does not capture keep their previous value.
module alu_sequencer #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [8:1] a_in,
  input  logic [8:1] b_in,
  output logic [8:1] a_bus,
  output logic [8:1] b_bus,
  output logic [7:1] unit_en,
  input  logic [8:1] res_bus,
  input  logic       carry,
  input  logic       zero,
  input  logic       negative,
  input  logic       overflow,
  input  logic       sign,
  input  logic       eq,
  output logic [8:1] acc,
  output logic [6:1] sreg,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] settle_cnt;
  logic [6:1] cap_mask;
  logic [6:1] flags_new;
  logic [6:1] sreg_next;

  // sreg layout {E,S,V,N,Z,C}: arithmetic owns C..S, compare owns E, logic/shift own Z,N
  always_comb begin
    cap_mask = 6'b000110;
    case (op_q)
      3'b000, 3'b001: cap_mask = 6'b011111;
      3'b010:         cap_mask = 6'b100000;
      default:        ;
    endcase
    flags_new = {eq, sign, overflow, negative, zero, carry} & cap_mask;
`ifdef ALU_SEQ_FLAG_PRESERVE_EN
    sreg_next = flags_new | (sreg & ~cap_mask);
`else
    sreg_next = flags_new;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      settle_cnt <= '0;
      a_bus      <= '0;
      b_bus      <= '0;
      unit_en    <= '0;
      acc        <= '0;
      sreg       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            // illegal opcode skips the unit entirely and reports straight away
            if (opcode == 3'b111) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= S_ISSUE;
              op_q    <= opcode;
              a_bus   <= a_in;
              b_bus   <= b_in;
              unit_en <= 7'd1 << opcode;
            end
          end
        end
        S_ISSUE: begin
          state      <= S_SETTLE;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          if (settle_cnt == 2'(SETTLE_CYC - 1)) state <= S_CAPTURE;
          else settle_cnt <= settle_cnt + 2'd1;
        end
        S_CAPTURE: begin
          state   <= S_DONE;
          acc     <= res_bus;
          sreg    <= sreg_next;
          unit_en <= '0;
          done    <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench for alu_sequencer with behavioural ALU units.
// Honours ALU_SEQ_FLAG_PRESERVE_EN when computing expected status flags.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, start3;
  logic [2:0] opcode;
  logic [7:0] a_in, b_in;

  logic [7:0] a_bus, b_bus, res_bus, acc;
  logic [6:0] unit_en;
  logic [5:0] sreg;
  logic       carry, zero, negative, overflow, sign, eq, busy, done, err;

  logic [7:0] a_bus3, b_bus3, res_bus3, acc3;
  logic [6:0] unit_en3;
  logic [5:0] sreg3;
  logic       carry3, zero3, negative3, overflow3, sign3, eq3, busy3, done3, err3;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl_acc;
  logic [5:0] mdl_sreg;

  int o_lat, o_en_cyc, o_en_bad, o_err_cyc, o_done_cyc, o_bus_bad;

  always #5 clk = ~clk;

  // Environment ALU units; unused flag lines carry operand-dependent junk to expose bad masking
  function automatic logic [13:0] unit_calc(input logic [7:0] a, input logic [7:0] b,
                                            input logic [6:0] en);
    logic [8:0] t;
    logic [7:0] r;
    logic       c, v, e, s, junk;
    junk = ^(a ^ b);
    t = '0; r = '0; c = junk; v = ~junk; e = junk; s = junk;
    case (en)
      7'b0000001: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[7:0]; c = t[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
        s = r[7] ^ v;
      end
      7'b0000010: begin
        t = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = t[7:0]; c = ~t[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
        s = r[7] ^ v;
      end
      7'b0000100: begin r = a; e = (a == b); end
      7'b0001000: r = a & b;
      7'b0010000: r = a | b;
      7'b0100000: r = a ^ b;
      7'b1000000: r = a << b[2:0];
      default:    r = 8'h00;
    endcase
    return {e, s, v, r[7], (r == 8'h00), c, r};
  endfunction

  assign {eq, sign, overflow, negative, zero, carry, res_bus} = unit_calc(a_bus, b_bus, unit_en);
  assign {eq3, sign3, overflow3, negative3, zero3, carry3, res_bus3} =
         unit_calc(a_bus3, b_bus3, unit_en3);

  alu_sequencer #(.SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a_in(a_in), .b_in(b_in),
    .a_bus(a_bus), .b_bus(b_bus), .unit_en(unit_en), .res_bus(res_bus),
    .carry(carry), .zero(zero), .negative(negative), .overflow(overflow), .sign(sign), .eq(eq),
    .acc(acc), .sreg(sreg), .busy(busy), .done(done), .err(err)
  );

  alu_sequencer #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .opcode(opcode), .a_in(a_in), .b_in(b_in),
    .a_bus(a_bus3), .b_bus(b_bus3), .unit_en(unit_en3), .res_bus(res_bus3),
    .carry(carry3), .zero(zero3), .negative(negative3), .overflow(overflow3), .sign(sign3),
    .eq(eq3), .acc(acc3), .sreg(sreg3), .busy(busy3), .done(done3), .err(err3)
  );

  // Reference: integer arithmetic straight from the opcode table; sreg index 0=C .. 5=E
  task automatic ref_apply(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, u, s;
    logic [7:0] r;
    logic [5:0] f, m;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    u = 0; s = 0; f = '0; m = 6'b000110;
    case (op)
      3'd0: begin u = ua + ub; s = sa + sb; f[0] = (u > 255); m = 6'b011111; end
      3'd1: begin u = ua - ub; s = sa - sb; f[0] = (ua < ub); m = 6'b011111; end
      3'd2: begin u = ua; f[5] = (ua == ub); m = 6'b100000; end
      3'd3: u = ua & ub;
      3'd4: u = ua | ub;
      3'd5: u = ua ^ ub;
      3'd6: u = ua << (ub % 8);
      default: return;
    endcase
    r = u[7:0];
    f[1] = (r == 8'h00);
    f[2] = r[7];
    f[3] = (op <= 3'd1) && (s > 127 || s < -128);
    f[4] = (op <= 3'd1) && (s < 0);
    mdl_acc = r;
`ifdef ALU_SEQ_FLAG_PRESERVE_EN
    mdl_sreg = (mdl_sreg & ~m) | (f & m);
`else
    mdl_sreg = f & m;
`endif
  endtask

  // Runs one operation on dut and records what was observed; poke re-pulses start while busy
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input bit poke);
    logic [6:0] exp_en;
    exp_en = (op == 3'b111) ? 7'd0 : (7'd1 << op);
    o_lat = -1; o_en_cyc = 0; o_en_bad = 0; o_err_cyc = 0; o_done_cyc = 0; o_bus_bad = 0;
    @(negedge clk);
    opcode = op; a_in = a; b_in = b; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && busy && !done) begin
        start  = 1'b1;
        opcode = 3'($urandom_range(0, 7));
        a_in   = 8'($urandom);
        b_in   = 8'($urandom);
      end
      if (done) begin
        o_done_cyc++;
        if (o_lat < 0) o_lat = k;
      end
      if (err) o_err_cyc++;
      if (unit_en != 7'd0) o_en_cyc++;
      if ((unit_en != 7'd0 && unit_en != exp_en) || $countones(unit_en) > 1) o_en_bad++;
      if (busy && op != 3'b111 && (a_bus !== a || b_bus !== b)) o_bus_bad++;
      if (!busy) break;
    end
    start = 1'b0;
    ref_apply(op, a, b);
  endtask

  task automatic test_reset;
    checks++;
    if (unit_en !== 7'd0 || a_bus !== 8'h00 || b_bus !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_buses: en=%b a=%h b=%h expected all zero", unit_en, a_bus, b_bus);
    end
    checks++;
    if (acc !== 8'h00 || sreg !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_acc_sreg: acc=%h sreg=%b expected 00/000000", acc, sreg);
    end
    checks++;
    if ({busy, done, err} !== 3'b000 || {busy3, done3, err3} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_status: got %b/%b expected 000/000",
               {busy, done, err}, {busy3, done3, err3});
    end
  endtask

  task automatic test_add_overflow;
    applyStimulus(3'd0, 8'h7F, 8'h01, 1'b0);
    checks++;
    if (o_lat !== 4) begin
      errors++; $display("[TB] FAIL add_latency: got %0d expected 4", o_lat);
    end
    checks++;
    if (o_en_cyc !== 3 || o_en_bad !== 0) begin
      errors++;
      $display("[TB] FAIL add_unit_en: cycles=%0d bad=%0d expected 3/0", o_en_cyc, o_en_bad);
    end
    checks++;
    if (acc !== 8'h80 || sreg !== 6'b001100) begin
      errors++;
      $display("[TB] FAIL add_result: acc=%h sreg=%b expected 80/001100", acc, sreg);
    end
  endtask

  task automatic test_sub_zero;
    int lat3;
    applyStimulus(3'd1, 8'h05, 8'h05, 1'b0);
    checks++;
    if (acc !== 8'h00 || sreg !== 6'b000010) begin
      errors++;
      $display("[TB] FAIL sub_result: acc=%h sreg=%b expected 00/000010", acc, sreg);
    end
    lat3 = -1;
    @(negedge clk);
    opcode = 3'd1; a_in = 8'h05; b_in = 8'h05; start3 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (done3 && lat3 < 0) lat3 = k;
      if (!busy3) break;
    end
    checks++;
    if (lat3 !== 6) begin
      errors++; $display("[TB] FAIL settle3_latency: got %0d expected 6", lat3);
    end
    checks++;
    if (acc3 !== 8'h00 || sreg3 !== 6'b000010) begin
      errors++;
      $display("[TB] FAIL settle3_result: acc=%h sreg=%b expected 00/000010", acc3, sreg3);
    end
  endtask

  task automatic test_cmp_ignore_start;
    applyStimulus(3'd2, 8'h3C, 8'h3C, 1'b1);
    checks++;
    if (o_done_cyc !== 1 || o_bus_bad !== 0) begin
      errors++;
      $display("[TB] FAIL cmp_single_done: dones=%0d bus_bad=%0d expected 1/0",
               o_done_cyc, o_bus_bad);
    end
    checks++;
    if (acc !== 8'h3C || sreg[5] !== 1'b1 || sreg !== mdl_sreg) begin
      errors++;
      $display("[TB] FAIL cmp_result: acc=%h sreg=%b expected 3c/%b", acc, sreg, mdl_sreg);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL cmp_no_restart: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_illegal;
    logic [7:0] prev_acc;
    logic [5:0] prev_sreg;
    prev_acc = mdl_acc;
    prev_sreg = mdl_sreg;
    applyStimulus(3'd7, 8'($urandom), 8'($urandom), 1'b0);
    checks++;
    if (o_lat !== 1 || o_err_cyc !== 1 || o_done_cyc !== 1 || o_en_cyc !== 0) begin
      errors++;
      $display("[TB] FAIL illegal_timing: lat=%0d err=%0d done=%0d en=%0d expected 1/1/1/0",
               o_lat, o_err_cyc, o_done_cyc, o_en_cyc);
    end
    checks++;
    if (acc !== prev_acc || sreg !== prev_sreg) begin
      errors++;
      $display("[TB] FAIL illegal_keep: acc=%h sreg=%b expected %h/%b",
               acc, sreg, prev_acc, prev_sreg);
    end
  endtask

  task automatic test_reset_midop;
    int dones;
    @(negedge clk);
    opcode = 3'd0; a_in = 8'h10; b_in = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || unit_en !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL midop_pre: busy=%b en=%b expected 1/0000001", busy, unit_en);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (unit_en !== 7'd0 || busy !== 1'b0 || acc !== 8'h00 || sreg !== 6'd0) begin
      errors++;
      $display("[TB] FAIL midop_async_reset: en=%b busy=%b acc=%h sreg=%b expected 0/0/00/0",
               unit_en, busy, acc, sreg);
    end
    mdl_acc = 8'h00;
    mdl_sreg = 6'd0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0 || acc !== 8'h00) begin
      errors++; $display("[TB] FAIL midop_no_done: dones=%0d acc=%h expected 0/00", dones, acc);
    end
    applyStimulus(3'd0, 8'h10, 8'h20, 1'b0);
    checks++;
    if (o_lat !== 4 || acc !== 8'h30) begin
      errors++;
      $display("[TB] FAIL post_reset_op: lat=%0d acc=%h expected 4/30", o_lat, acc);
    end
  endtask

  task automatic test_flag_preserve;
    logic exp_c;
`ifdef ALU_SEQ_FLAG_PRESERVE_EN
    exp_c = 1'b1;
`else
    exp_c = 1'b0;
`endif
    applyStimulus(3'd0, 8'hFF, 8'h01, 1'b0);
    checks++;
    if (acc !== 8'h00 || sreg[1:0] !== 2'b11) begin
      errors++;
      $display("[TB] FAIL carry_set: acc=%h Z,C=%b expected 00/11", acc, sreg[1:0]);
    end
    applyStimulus(3'd3, 8'h0F, 8'hF0, 1'b0);
    checks++;
    if (sreg[1] !== 1'b1 || sreg[0] !== exp_c) begin
      errors++;
      $display("[TB] FAIL and_flags: Z=%b C=%b expected 1/%b", sreg[1], sreg[0], exp_c);
    end
  endtask

  task automatic test_random;
    logic [2:0] op;
    logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 5 == 0) b = a;
      applyStimulus(op, a, b, 1'($urandom_range(0, 1)));
      checks++;
      if (acc !== mdl_acc || sreg !== mdl_sreg) begin
        errors++;
        $display("[TB] FAIL rand_result op=%0d a=%h b=%h: acc=%h sreg=%b expected %h/%b",
                 op, a, b, acc, sreg, mdl_acc, mdl_sreg);
      end
      checks++;
      if (o_lat !== ((op == 3'd7) ? 1 : 4) || o_done_cyc !== 1 ||
          o_err_cyc !== ((op == 3'd7) ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL rand_timing op=%0d: lat=%0d done=%0d err=%0d", op, o_lat,
                 o_done_cyc, o_err_cyc);
      end
      checks++;
      if (o_en_bad !== 0 || o_bus_bad !== 0 || o_en_cyc !== ((op == 3'd7) ? 0 : 3)) begin
        errors++;
        $display("[TB] FAIL rand_enables op=%0d: en_cyc=%0d en_bad=%0d bus_bad=%0d",
                 op, o_en_cyc, o_en_bad, o_bus_bad);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    opcode = 3'd0; a_in = 8'h00; b_in = 8'h00;
    mdl_acc = 8'h00; mdl_sreg = 6'd0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_add_overflow;
    test_sub_zero;
    test_cmp_ignore_start;
    test_illegal;
    test_reset_midop;
    test_flag_preserve;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
